// File: rtl/branch_history_table.sv
// branch_history_table: table of ENTRIES saturating CTR_BITS-bit counters
// indexed by word-aligned PC. Combinational prediction read, registered
// update port, saturating misprediction counter.
// Optional: define BHT_GSHARE_EN to XOR a global history register into
// both indices and expose it on bht_ghr.
module branch_history_table #(
    parameter int unsigned ENTRIES   = 64,
    parameter int unsigned CTR_BITS  = 2,
    parameter int unsigned PC_BITS   = 32,
    parameter int unsigned INIT_CTR  = 2**(CTR_BITS-1)-1,
    parameter int unsigned MISS_BITS = 16,
    parameter int unsigned GHR_BITS  = 6
) (
    input  logic                 bht_clk,
    input  logic                 bht_rst,
    input  logic [PC_BITS-1:0]   bht_pred_pc,
    output logic                 bht_pred_taken,
    output logic [CTR_BITS-1:0]  bht_pred_ctr,
    input  logic                 bht_upd_valid,
    input  logic [PC_BITS-1:0]   bht_upd_pc,
    input  logic                 bht_upd_taken,
    input  logic                 bht_upd_pred,
    output logic [MISS_BITS-1:0] bht_miss_count
`ifdef BHT_GSHARE_EN
    ,
    output logic [GHR_BITS-1:0]  bht_ghr
`endif
);

    localparam int unsigned IDX_BITS = $clog2(ENTRIES);

    logic [CTR_BITS-1:0]  ctr_table [ENTRIES];
    logic [MISS_BITS-1:0] miss_q;
    logic [IDX_BITS-1:0]  pred_idx;
    logic [IDX_BITS-1:0]  upd_idx;
    logic [CTR_BITS-1:0]  upd_cur;
    logic [CTR_BITS-1:0]  upd_next;
    logic [IDX_BITS-1:0]  hist_mix;

    // PC bits outside the index field carry no information for this table
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bht_pred_pc[PC_BITS-1:IDX_BITS+2], bht_pred_pc[1:0],
                              bht_upd_pc[PC_BITS-1:IDX_BITS+2], bht_upd_pc[1:0]};

`ifdef BHT_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q;

    // Zero-extend the global history to index width
    always_comb begin
        hist_mix = '0;
        hist_mix[GHR_BITS-1:0] = ghr_q;
    end

    // History shifts in each resolved outcome at bit 0
    always_ff @(posedge bht_clk) begin
        if (bht_rst) begin
            ghr_q <= '0;
        end else if (bht_upd_valid) begin
            ghr_q <= (ghr_q << 1) | GHR_BITS'(bht_upd_taken);
        end
    end

    assign bht_ghr = ghr_q;
`else
    assign hist_mix = '0;
`endif

    // Index formation and zero-latency prediction read (no write forwarding)
    always_comb begin
        pred_idx       = bht_pred_pc[IDX_BITS+1:2] ^ hist_mix;
        upd_idx        = bht_upd_pc[IDX_BITS+1:2] ^ hist_mix;
        bht_pred_ctr   = ctr_table[pred_idx];
        bht_pred_taken = bht_pred_ctr[CTR_BITS-1];
    end

    // Saturating increment/decrement of the counter being updated
    always_comb begin
        upd_cur  = ctr_table[upd_idx];
        upd_next = upd_cur;
        if (bht_upd_taken) begin
            if (upd_cur != '1) upd_next = upd_cur + 1'b1;
        end else begin
            if (upd_cur != '0) upd_next = upd_cur - 1'b1;
        end
    end

    // Counter table: reset to INIT_CTR, single-entry write per valid update
    always_ff @(posedge bht_clk) begin
        if (bht_rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_table[i] <= CTR_BITS'(INIT_CTR);
            end
        end else if (bht_upd_valid) begin
            ctr_table[upd_idx] <= upd_next;
        end
    end

    // Misprediction statistics, saturating at all-ones
    always_ff @(posedge bht_clk) begin
        if (bht_rst) begin
            miss_q <= '0;
        end else if (bht_upd_valid && (bht_upd_taken != bht_upd_pred) && (miss_q != '1)) begin
            miss_q <= miss_q + 1'b1;
        end
    end

    assign bht_miss_count = miss_q;

endmodule

// File: tb/tb_branch_history_table.sv
// tb_branch_history_table: directed vectors with hand-computed expectations
// for branch_history_table (ENTRIES=64, CTR_BITS=2, MISS_BITS=4).
module tb_branch_history_table;

    logic        clk;
    logic        rst;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [1:0]  pred_ctr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_pred;
    logic [3:0]  miss_count;
`ifdef BHT_GSHARE_EN
    logic [5:0]  ghr;
`endif

    int errors = 0;
    int checks = 0;

    branch_history_table #(
        .ENTRIES   (64),
        .CTR_BITS  (2),
        .PC_BITS   (32),
        .MISS_BITS (4),
        .GHR_BITS  (6)
    ) dut (
        .bht_clk        (clk),
        .bht_rst        (rst),
        .bht_pred_pc    (pred_pc),
        .bht_pred_taken (pred_taken),
        .bht_pred_ctr   (pred_ctr),
        .bht_upd_valid  (upd_valid),
        .bht_upd_pc     (upd_pc),
        .bht_upd_taken  (upd_taken),
        .bht_upd_pred   (upd_pred),
        .bht_miss_count (miss_count)
`ifdef BHT_GSHARE_EN
        ,
        .bht_ghr        (ghr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one valid update for exactly one rising edge; return #1 after it
    task automatic do_upd(input logic [31:0] pc, input logic taken, input logic pred);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = taken;
        upd_pred  = pred;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic read_ctr(input string tag, input logic [31:0] pc, input logic [1:0] exp);
        pred_pc = pc;
        #1;
        check(tag, {30'd0, pred_ctr}, {30'd0, exp});
        check({tag, "_tk"}, {31'd0, pred_taken}, {31'd0, exp[1]});
    endtask

    initial begin
        rst       = 1'b1;
        pred_pc   = '0;
        upd_valid = 1'b0;
        upd_pc    = '0;
        upd_taken = 1'b0;
        upd_pred  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state: every entry weakly not-taken, no misses
        read_ctr("rst_100", 32'h100, 2'b01);
        read_ctr("rst_1fc", 32'h1FC, 2'b01);
        check("rst_miss", {28'd0, miss_count}, 32'd0);

`ifndef BHT_GSHARE_EN
        // Saturate up at 0x40 with mispredicted taken outcomes
        do_upd(32'h40, 1'b1, 1'b0); read_ctr("up1", 32'h40, 2'b10);
        do_upd(32'h40, 1'b1, 1'b0); read_ctr("up2", 32'h40, 2'b11);
        do_upd(32'h40, 1'b1, 1'b0); read_ctr("up3", 32'h40, 2'b11);
        check("up_miss", {28'd0, miss_count}, 32'd3);

        // Saturate down; 0x140 aliases onto the same entry
        do_upd(32'h40, 1'b0, 1'b1); read_ctr("dn1", 32'h140, 2'b10);
        do_upd(32'h40, 1'b0, 1'b1); read_ctr("dn2", 32'h140, 2'b01);
        do_upd(32'h40, 1'b0, 1'b1); read_ctr("dn3", 32'h140, 2'b00);
        do_upd(32'h40, 1'b0, 1'b1); read_ctr("dn4", 32'h40, 2'b00);
        check("dn_miss", {28'd0, miss_count}, 32'd7);

        // Same-cycle read of the entry being written returns the old value
        upd_valid = 1'b1;
        upd_pc    = 32'h80;
        upd_taken = 1'b1;
        upd_pred  = 1'b1;
        read_ctr("rw_old", 32'h80, 2'b01);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        read_ctr("rw_new", 32'h80, 2'b10);
        read_ctr("rw_nbr", 32'h84, 2'b01);
        check("rw_miss", {28'd0, miss_count}, 32'd7);

        // Idle update bus: nothing changes even with a would-be miss present
        upd_pc    = 32'h80;
        upd_taken = 1'b0;
        upd_pred  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        read_ctr("idle_ctr", 32'h80, 2'b10);
        check("idle_miss", {28'd0, miss_count}, 32'd7);

        // Mid-stream reset together with a valid update: update discarded
        rst = 1'b1;
        do_upd(32'h84, 1'b1, 1'b0);
        rst = 1'b0;
        read_ctr("mrst_40", 32'h40, 2'b01);
        read_ctr("mrst_80", 32'h80, 2'b01);
        read_ctr("mrst_84", 32'h84, 2'b01);
        check("mrst_miss", {28'd0, miss_count}, 32'd0);

        // Miss counter saturates at 15 (MISS_BITS=4) without wrapping
        for (int i = 0; i < 15; i++) do_upd(32'hC0, 1'b1, 1'b0);
        check("sat15", {28'd0, miss_count}, 32'd15);
        for (int i = 0; i < 2; i++) do_upd(32'hC0, 1'b1, 1'b0);
        check("sat17", {28'd0, miss_count}, 32'd15);
        read_ctr("sat_ctr", 32'hC0, 2'b11);
`else
        // Global history: T,T,N from PC 0 land in entries 0,1,3
        do_upd(32'h0, 1'b1, 1'b0);
        check("ghr1", {26'd0, ghr}, 32'h01);
        do_upd(32'h0, 1'b1, 1'b0);
        check("ghr2", {26'd0, ghr}, 32'h03);
        do_upd(32'h0, 1'b0, 1'b0);
        check("ghr3", {26'd0, ghr}, 32'h06);
        read_ctr("g_pc0_e6", 32'h0, 2'b01);
        read_ctr("g_pc18_e0", 32'h18, 2'b10);
        read_ctr("g_pc14_e3", 32'h14, 2'b00);
        check("g_miss", {28'd0, miss_count}, 32'd2);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("g_rst_ghr", {26'd0, ghr}, 32'd0);
        check("g_rst_miss", {28'd0, miss_count}, 32'd0);
        read_ctr("g_rst_e0", 32'h0, 2'b01);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
